// File: rtl/zorgian_pkg.sv
// Coin encodings, acceptor states and coin decode helpers shared by the Zorgian payment blocks.
// Pure definitions: no latency, no flow control.
package zorgian_pkg;

    typedef enum logic [2:0] {
        COIN_NONE = 3'b000,
        COIN_1    = 3'b001,
        COIN_3    = 3'b011,
        COIN_5    = 3'b101
    } coin_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } acc_state_t;

    function automatic logic coin_is_valid(input logic [2:0] code);
        return (code == COIN_1) || (code == COIN_3) || (code == COIN_5);
    endfunction

    function automatic logic [3:0] coin_value(input logic [2:0] code);
        case (code)
            COIN_1:  return 4'd1;
            COIN_3:  return 4'd3;
            COIN_5:  return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/zorgian_coin_acceptor_rising_edge_detect.sv
// Synchronises a raw button level and emits a 1-cycle pulse per rising edge, 2 cycles after the input rises.
// No backpressure; history resets high so a level held through reset never produces a pulse.
module rising_edge_detect (
    input  logic CLOCK_100,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge CLOCK_100) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign pulse = sync2 & ~hist;

endmodule

// File: rtl/zorgian_coin_acceptor.sv
// Accumulates coins against a latched cost and offers the amount paid on a valid/ack handshake.
// Completion is registered one cycle after the deciding coin; Paid and flags hold in DONE until ack.
module zorgian_coin_acceptor
    import zorgian_pkg::*;
#(
    parameter int          MAX_COINS      = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
    localparam int         CW = ($clog2(MAX_COINS + 1) > 4) ? $clog2(MAX_COINS + 1) : 4
) (
    input  logic          CLOCK_100,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    Cost,
    input  logic          coin_btn,
    input  logic [2:0]    coin_sel,
    input  logic          cancel,
    input  logic          ack,
    output logic [3:0]    Paid,
    output logic          paid_valid,
    output logic          busy,
    output logic          Overpaid,
    output logic          Short,
    output logic          bad_coin,
    output logic          cancelled,
    output logic [CW-1:0] coin_count
);

    acc_state_t    state, state_n;
    logic [3:0]    cost_q, cost_n;
    logic [4:0]    sum5, sum_n;
    logic [CW-1:0] count, count_n;
    logic [31:0]   tmo, tmo_n;
    logic          short_q, short_n;
    logic          bad_q, bad_n;
    logic          canc_q, canc_n;

    logic          coin_edge;
    logic          coin_ok;
    logic [4:0]    sum_add;
    logic [CW-1:0] count_inc;

    rising_edge_detect u_coin_edge (
        .CLOCK_100 (CLOCK_100),
        .reset     (reset),
        .in        (coin_btn),
        .pulse     (coin_edge)
    );

    assign coin_ok   = coin_is_valid(coin_sel);
    assign sum_add   = sum5 + {1'b0, coin_value(coin_sel)};
    assign count_inc = count + CW'(1);

    always_ff @(posedge CLOCK_100) begin
        if (reset) begin
            state   <= IDLE;
            cost_q  <= 4'd0;
            sum5    <= 5'd0;
            count   <= '0;
            tmo     <= 32'd0;
            short_q <= 1'b0;
            bad_q   <= 1'b0;
            canc_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cost_q  <= cost_n;
            sum5    <= sum_n;
            count   <= count_n;
            tmo     <= tmo_n;
            short_q <= short_n;
            bad_q   <= bad_n;
            canc_q  <= canc_n;
        end
    end

    always_comb begin
        state_n = state;
        cost_n  = cost_q;
        sum_n   = sum5;
        count_n = count;
        tmo_n   = tmo;
        short_n = short_q;
        bad_n   = 1'b0;
        canc_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = COLLECT;
                    cost_n  = Cost;
                    sum_n   = 5'd0;
                    count_n = '0;
                    tmo_n   = 32'd0;
                    short_n = 1'b0;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    state_n = IDLE;
                    sum_n   = 5'd0;
                    count_n = '0;
                    tmo_n   = 32'd0;
                    canc_n  = 1'b1;
                end else if (coin_edge && coin_ok) begin
                    sum_n   = sum_add;
                    count_n = count_inc;
                    tmo_n   = 32'd0;
                    if ((sum_add >= {1'b0, cost_q}) || (count_inc == CW'(MAX_COINS))) begin
                        state_n = DONE;
                        short_n = (sum_add < {1'b0, cost_q});
                    end
                end else begin
                    // Idle or rejected-coin cycle: only a zero cost or the timeout can end it.
                    bad_n = coin_edge;
                    if ((sum5 >= {1'b0, cost_q}) || (tmo == TIMEOUT_CYCLES - 32'd1)) begin
                        state_n = DONE;
                        short_n = (sum5 < {1'b0, cost_q});
                    end else begin
                        tmo_n = tmo + 32'd1;
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign Paid       = sum5[4] ? 4'd15 : sum5[3:0];
    assign Overpaid   = sum5[4];
    assign Short      = short_q;
    assign paid_valid = (state == DONE);
    assign busy       = (state != IDLE);
    assign bad_coin   = bad_q;
    assign cancelled  = canc_q;
    assign coin_count = count;

endmodule

// File: tb/tb_zorgian_coin_acceptor.sv
// Scoreboarded bench for zorgian_coin_acceptor: directed scenarios plus randomized transactions.
module tb_zorgian_coin_acceptor;

    logic       CLOCK_100 = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] Cost = 4'd0;
    logic       coin_btn = 1'b0;
    logic [2:0] coin_sel = 3'd0;
    logic       cancel = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] Paid;
    logic       paid_valid;
    logic       busy;
    logic       Overpaid;
    logic       Short;
    logic       bad_coin;
    logic       cancelled;
    logic [3:0] coin_count;

    always #5 CLOCK_100 = ~CLOCK_100;

    zorgian_coin_acceptor #(.MAX_COINS(8), .TIMEOUT_CYCLES(32'd16)) dut (
        .CLOCK_100  (CLOCK_100),
        .reset      (reset),
        .start      (start),
        .Cost       (Cost),
        .coin_btn   (coin_btn),
        .coin_sel   (coin_sel),
        .cancel     (cancel),
        .ack        (ack),
        .Paid       (Paid),
        .paid_valid (paid_valid),
        .busy       (busy),
        .Overpaid   (Overpaid),
        .Short      (Short),
        .bad_coin   (bad_coin),
        .cancelled  (cancelled),
        .coin_count (coin_count)
    );

    typedef struct {
        int paid;
        int over;
        int shrt;
        int cnt;
    } res_t;

    res_t       exp_q[$];
    logic [2:0] plan[$];
    int total = 0, passed = 0;
    int exp_bad = 0, exp_canc = 0, seen_bad = 0, seen_canc = 0;
    bit pv_d = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int zval(input logic [2:0] c);
        case (c)
            3'b001:  return 1;
            3'b011:  return 3;
            3'b101:  return 5;
            default: return 0;
        endcase
    endfunction

    task automatic push_exp(input int sum, input int cost, input int cnt);
        res_t r;
        r.paid = (sum > 15) ? 15 : sum;
        r.over = (sum > 15) ? 1 : 0;
        r.shrt = (sum < cost) ? 1 : 0;
        r.cnt  = cnt;
        exp_q.push_back(r);
    endtask

    // Monitor: pops one expected result each time a completed amount is offered.
    always @(negedge CLOCK_100) begin
        res_t r;
        if (bad_coin) seen_bad++;
        if (cancelled) seen_canc++;
        if (paid_valid && !pv_d) begin
            chk("sb_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("Paid", int'(Paid), r.paid);
                chk("Overpaid", int'(Overpaid), r.over);
                chk("Short", int'(Short), r.shrt);
                chk("coin_count", int'(coin_count), r.cnt);
            end
        end
        pv_d = paid_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_100);
        #1;
    endtask

    task automatic begin_txn(input int cost);
        @(posedge CLOCK_100); #1;
        start = 1'b1;
        Cost  = 4'(cost);
        tick(1);
        start = 1'b0;
    endtask

    task automatic press(input logic [2:0] code, input bit with_cancel);
        @(posedge CLOCK_100); #1;
        coin_sel = code;
        coin_btn = 1'b1;
        tick(2);
        if (with_cancel) cancel = 1'b1;
        tick(1);
        cancel   = 1'b0;
        coin_btn = 1'b0;
        tick(3);
    endtask

    task automatic cancel_pulse();
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
        tick(1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!paid_valid && n < 40) begin
            tick(1);
            n++;
        end
        chk("done_reached", int'(paid_valid), 1);
    endtask

    task automatic finish_txn();
        wait_valid();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("ack_busy", int'(busy), 0);
        chk("ack_valid", int'(paid_valid), 0);
    endtask

    function automatic logic [2:0] rand_code(input bit valid_only);
        int k;
        if (!valid_only && $urandom_range(0, 4) == 0) begin
            k = $urandom_range(0, 4);
            case (k)
                0: return 3'b000;
                1: return 3'b010;
                2: return 3'b100;
                3: return 3'b110;
                default: return 3'b111;
            endcase
        end
        k = $urandom_range(0, 2);
        case (k)
            0: return 3'b001;
            1: return 3'b011;
            default: return 3'b101;
        endcase
    endfunction

    task automatic do_txn(input int cost, input bit allow_cancel);
        int sum = 0, cnt = 0, v;
        bit prev_bad = 1'b0;
        logic [2:0] code;
        begin_txn(cost);
        if (cost == 0) begin
            push_exp(0, 0, 0);
            finish_txn();
            return;
        end
        while (1) begin
            if (allow_cancel && $urandom_range(0, 11) == 0) begin
                cancel_pulse();
                exp_canc++;
                chk("cancel_busy", int'(busy), 0);
                chk("cancel_paid", int'(Paid), 0);
                return;
            end
            if (plan.size() > 0) code = plan.pop_front();
            else code = rand_code(prev_bad);
            v = zval(code);
            if (v == 0) begin
                exp_bad++;
                prev_bad = 1'b1;
                press(code, 1'b0);
            end else begin
                prev_bad = 1'b0;
                sum += v;
                cnt++;
                if (sum >= cost || cnt == 8) begin
                    push_exp(sum, cost, cnt);
                    press(code, 1'b0);
                    finish_txn();
                    return;
                end
                press(code, 1'b0);
            end
            chk("paid_mid", int'(Paid), sum);
            chk("count_mid", int'(coin_count), cnt);
            chk("busy_mid", int'(busy), 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got running, expected finished");
        $fatal(1);
    end

    initial begin
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_Paid", int'(Paid), 0);
        chk("rst_paid_valid", int'(paid_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_Overpaid", int'(Overpaid), 0);
        chk("rst_Short", int'(Short), 0);
        chk("rst_bad_coin", int'(bad_coin), 0);
        chk("rst_cancelled", int'(cancelled), 0);
        chk("rst_coin_count", int'(coin_count), 0);

        // Exact payment path, with a coin and a cancel offered while DONE.
        begin_txn(7);
        press(3'b101, 1'b0);
        chk("t1_paid_first", int'(Paid), 5);
        push_exp(8, 7, 2);
        press(3'b011, 1'b0);
        wait_valid();
        press(3'b101, 1'b0);
        cancel_pulse();
        chk("t1_done_hold_valid", int'(paid_valid), 1);
        chk("t1_done_hold_paid", int'(Paid), 8);
        chk("t1_done_hold_count", int'(coin_count), 2);
        finish_txn();

        plan = '{3'b101, 3'b101, 3'b101};
        do_txn(15, 1'b0);
        plan = '{3'b101, 3'b101, 3'b011, 3'b011};
        do_txn(14, 1'b0);

        // Timeout with a partial payment.
        begin_txn(9);
        press(3'b001, 1'b0);
        push_exp(1, 9, 1);
        tick(6);
        chk("t3_not_yet_done", int'(paid_valid), 0);
        finish_txn();

        // Invalid code, then cancel racing a coin edge.
        begin_txn(10);
        press(3'b011, 1'b0);
        press(3'b010, 1'b0);
        exp_bad++;
        chk("t4_paid_after_bad", int'(Paid), 3);
        chk("t4_count_after_bad", int'(coin_count), 1);
        press(3'b101, 1'b1);
        exp_canc++;
        chk("t4_cancel_busy", int'(busy), 0);
        chk("t4_cancel_paid", int'(Paid), 0);

        plan = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        do_txn(15, 1'b0);

        // Button held through reset release while a transaction starts immediately.
        coin_sel = 3'b001;
        coin_btn = 1'b1;
        reset    = 1'b1;
        start    = 1'b1;
        Cost     = 4'd5;
        tick(3);
        reset = 1'b0;
        tick(1);
        start = 1'b0;
        tick(6);
        chk("t6_held_count", int'(coin_count), 0);
        chk("t6_held_busy", int'(busy), 1);
        coin_btn = 1'b0;
        tick(3);
        cancel_pulse();
        exp_canc++;

        // Reset while DONE.
        begin_txn(3);
        push_exp(3, 3, 1);
        press(3'b011, 1'b0);
        wait_valid();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_rst_done_valid", int'(paid_valid), 0);
        chk("t6_rst_done_paid", int'(Paid), 0);
        chk("t6_rst_done_busy", int'(busy), 0);

        do_txn(0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            do_txn($urandom_range(0, 15), 1'b1);
        end

        tick(5);
        chk("bad_coin_pulses", seen_bad, exp_bad);
        chk("cancelled_pulses", seen_canc, exp_canc);
        chk("sb_leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
